region_color_tracker: RTL and testbench

//   Parametrised successor to the fixed 4-region colour tracker + smoother pair.

---
 rtl/region_color_tracker.sv | 184 ++++++++++++++++++
 tb/tb_region_color_tracker.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/region_color_tracker.sv
// Per-strip colour-hit counter with frame-level winner / threshold selection
// and per-flag debouncing across consecutive frames.
module region_color_tracker #(
    parameter int NUM_REGIONS = 4,
    parameter int FRAME_WIDTH = 640,
    parameter int CNT_W       = 17,
    parameter int THRESHOLD   = 2000,
    parameter int HYST_FRAMES = 3
) (
    input  logic                           PCLK,
    input  logic                           rst,
    input  logic                           VSYNC,
    input  logic                           HREF,
    input  logic                           e_pix,
    input  logic                           hit,
    input  logic                           mode,
    output logic [NUM_REGIONS-1:0]         region_flags,
    output logic [$clog2(NUM_REGIONS)-1:0] winner_idx,
    output logic                           winner_valid,
    output logic                           frame_done
);

    localparam int REGION_WIDTH = FRAME_WIDTH / NUM_REGIONS;
    localparam int IDX_W = $clog2(NUM_REGIONS);
    localparam int COL_W = $clog2(NUM_REGIONS + 1);
    localparam int SUB_W = (REGION_WIDTH > 1) ? $clog2(REGION_WIDTH) : 1;
    localparam int AGR_W = (HYST_FRAMES > 1) ? $clog2(HYST_FRAMES) : 1;
    localparam logic [63:0] THR64 = 64'(THRESHOLD);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_EVAL  = 2'd2;
    localparam logic [1:0] S_UPD   = 2'd3;

    logic                   r_vsync;
    logic                   r_href;
    logic                   r_vs_rise;
    logic [1:0]             r_state;
    logic [SUB_W-1:0]       r_sub_col;
    logic [COL_W-1:0]       r_col_region;
    logic [CNT_W-1:0]       r_cnt [NUM_REGIONS];
    logic [AGR_W-1:0]       r_agree [NUM_REGIONS];
    logic [IDX_W-1:0]       r_eval_idx;
    logic                   r_mode;
    logic [NUM_REGIONS-1:0] r_qual;
    logic [IDX_W-1:0]       r_best_idx;
    logic [CNT_W-1:0]       r_best_cnt;
    logic                   r_best_vld;

    logic                   w_href_rise;
    logic                   w_pix;
    logic [CNT_W-1:0]       w_cur_cnt;
    logic                   w_cur_qual;
    logic [NUM_REGIONS-1:0] w_cand;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    assign w_href_rise = HREF & ~r_href;
    assign w_pix       = e_pix & HREF;
    assign w_cur_qual  = (64'(w_cur_cnt) >= THR64);

    always_comb begin
        w_cur_cnt = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (r_eval_idx == IDX_W'(i)) w_cur_cnt = r_cnt[i];
        end
    end

    always_comb begin
        w_cand = '0;
        if (r_mode) begin
            w_cand = r_qual;
        end else if (r_best_vld) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                if (r_best_idx == IDX_W'(i)) w_cand[i] = 1'b1;
            end
        end
    end

    // Input edge detection and column-to-strip tracking (strip index sticks past the last strip)
    always_ff @(posedge PCLK or posedge rst) begin
        if (rst) begin
            r_vsync      <= 1'b0;
            r_href       <= 1'b0;
            r_vs_rise    <= 1'b0;
            r_sub_col    <= '0;
            r_col_region <= '0;
        end else begin
            r_vsync   <= VSYNC;
            r_href    <= HREF;
            r_vs_rise <= VSYNC & ~r_vsync;
            if (w_href_rise) begin
                r_sub_col    <= '0;
                r_col_region <= '0;
            end else if (w_pix && (r_col_region != COL_W'(NUM_REGIONS))) begin
                if (r_sub_col == SUB_W'(REGION_WIDTH - 1)) begin
                    r_sub_col    <= '0;
                    r_col_region <= r_col_region + COL_W'(1);
                end else begin
                    r_sub_col <= r_sub_col + SUB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge PCLK or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_eval_idx   <= '0;
            r_mode       <= 1'b0;
            r_qual       <= '0;
            r_best_idx   <= '0;
            r_best_cnt   <= '0;
            r_best_vld   <= 1'b0;
            region_flags <= '0;
            winner_idx   <= '0;
            winner_valid <= 1'b0;
            frame_done   <= 1'b0;
            for (int i = 0; i < NUM_REGIONS; i++) begin
                r_cnt[i]   <= '0;
                r_agree[i] <= '0;
            end
        end else begin
            frame_done <= 1'b0;
            if (r_state == S_ACCUM) begin
                for (int i = 0; i < NUM_REGIONS; i++) begin
                    if (w_pix && hit && (r_col_region == COL_W'(i))) r_cnt[i] <= sat_inc(r_cnt[i]);
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (r_vs_rise) begin
                        r_state <= S_ACCUM;
                        for (int i = 0; i < NUM_REGIONS; i++) r_cnt[i] <= '0;
                    end
                end
                S_ACCUM: begin
                    if (r_vs_rise) begin
                        r_state    <= S_EVAL;
                        r_eval_idx <= '0;
                        r_mode     <= mode;
                        r_best_idx <= '0;
                        r_best_cnt <= '0;
                        r_best_vld <= 1'b0;
                    end
                end
                S_EVAL: begin
                    for (int i = 0; i < NUM_REGIONS; i++) begin
                        if (r_eval_idx == IDX_W'(i)) r_qual[i] <= w_cur_qual;
                    end
                    // Strict '>' keeps the lower index on ties
                    if (w_cur_qual && (!r_best_vld || (w_cur_cnt > r_best_cnt))) begin
                        r_best_vld <= 1'b1;
                        r_best_cnt <= w_cur_cnt;
                        r_best_idx <= r_eval_idx;
                    end
                    if (r_eval_idx == IDX_W'(NUM_REGIONS - 1)) r_state <= S_UPD;
                    else r_eval_idx <= r_eval_idx + IDX_W'(1);
                end
                S_UPD: begin
                    for (int i = 0; i < NUM_REGIONS; i++) begin
                        r_cnt[i] <= '0;
                        if (w_cand[i] == region_flags[i]) begin
                            r_agree[i] <= '0;
                        end else if (r_agree[i] == AGR_W'(HYST_FRAMES - 1)) begin
                            region_flags[i] <= ~region_flags[i];
                            r_agree[i]      <= '0;
                        end else begin
                            r_agree[i] <= r_agree[i] + AGR_W'(1);
                        end
                    end
                    winner_idx   <= r_best_idx;
                    winner_valid <= r_best_vld;
                    frame_done   <= 1'b1;
                    r_state      <= S_ACCUM;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_region_color_tracker.sv
// Directed bench for region_color_tracker: three parameterisations share one
// stimulus stream, each scenario checks the instance it targets.
module tb_region_color_tracker;

    logic PCLK = 1'b0;
    logic rst = 1'b1;
    logic VSYNC = 1'b0;
    logic HREF = 1'b0;
    logic e_pix = 1'b0;
    logic hit = 1'b0;
    logic mode = 1'b0;

    logic [3:0] fl_a, fl_h, fl_s;
    logic [1:0] wi_a, wi_h, wi_s;
    logic       wv_a, wv_h, wv_s;
    logic       fd_a, fd_h, fd_s;

    int total = 0;
    int bad = 0;
    int bud [5];

    always #5 PCLK = ~PCLK;

    region_color_tracker #(.NUM_REGIONS(4), .FRAME_WIDTH(640), .CNT_W(17),
                           .THRESHOLD(2000), .HYST_FRAMES(1)) u_a (
        .PCLK(PCLK), .rst(rst), .VSYNC(VSYNC), .HREF(HREF), .e_pix(e_pix),
        .hit(hit), .mode(mode), .region_flags(fl_a), .winner_idx(wi_a),
        .winner_valid(wv_a), .frame_done(fd_a));

    region_color_tracker #(.NUM_REGIONS(4), .FRAME_WIDTH(640), .CNT_W(17),
                           .THRESHOLD(100), .HYST_FRAMES(3)) u_h (
        .PCLK(PCLK), .rst(rst), .VSYNC(VSYNC), .HREF(HREF), .e_pix(e_pix),
        .hit(hit), .mode(mode), .region_flags(fl_h), .winner_idx(wi_h),
        .winner_valid(wv_h), .frame_done(fd_h));

    region_color_tracker #(.NUM_REGIONS(4), .FRAME_WIDTH(640), .CNT_W(8),
                           .THRESHOLD(200), .HYST_FRAMES(1)) u_s (
        .PCLK(PCLK), .rst(rst), .VSYNC(VSYNC), .HREF(HREF), .e_pix(e_pix),
        .hit(hit), .mode(mode), .region_flags(fl_s), .winner_idx(wi_s),
        .winner_valid(wv_s), .frame_done(fd_s));

    task automatic clear_bud();
        for (int r = 0; r < 5; r++) bud[r] = 0;
    endtask

    task automatic do_reset();
        @(negedge PCLK);
        rst = 1'b1; VSYNC = 1'b0; HREF = 1'b0; e_pix = 1'b0; hit = 1'b0;
        repeat (2) @(negedge PCLK);
        rst = 1'b0;
        @(negedge PCLK);
    endtask

    // One line: HREF rises, one idle cycle, then npix back-to-back pixels
    task automatic send_line(input int npix, input logic [4:0] mask);
        @(negedge PCLK);
        HREF = 1'b1; e_pix = 1'b0; hit = 1'b0;
        @(negedge PCLK);
        for (int c = 0; c < npix; c++) begin
            int r;
            r = (c >= 640) ? 4 : c / 160;
            e_pix = 1'b1;
            hit = 1'b0;
            if (mask[r] && bud[r] > 0) begin
                hit = 1'b1;
                bud[r] = bud[r] - 1;
            end
            @(negedge PCLK);
        end
        e_pix = 1'b0; hit = 1'b0; HREF = 1'b0;
        repeat (2) @(negedge PCLK);
    endtask

    task automatic start_frame();
        @(negedge PCLK);
        VSYNC = 1'b1;
        repeat (3) @(negedge PCLK);
        VSYNC = 1'b0;
        repeat (2) @(negedge PCLK);
    endtask

    // cyc counts PCLK edges after the edge that samples the VSYNC rise
    task automatic end_frame(input int sel, output int cyc, output logic got);
        @(negedge PCLK);
        VSYNC = 1'b1;
        @(posedge PCLK);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 40) begin
            @(posedge PCLK);
            cyc++;
            #1;
            got = (sel == 0) ? fd_a : (sel == 1) ? fd_h : fd_s;
        end
        @(negedge PCLK);
        VSYNC = 1'b0;
        repeat (2) @(negedge PCLK);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge PCLK);
        total++;
        if ({fl_a, wi_a, wv_a, fd_a} !== 8'h00) begin
            bad++; $display("FAIL reset_a: got %0h expected 0", {fl_a, wi_a, wv_a, fd_a});
        end
        total++;
        if ({fl_h, wi_h, wv_h, fd_h} !== 8'h00) begin
            bad++; $display("FAIL reset_h: got %0h expected 0", {fl_h, wi_h, wv_h, fd_h});
        end
        total++;
        if ({fl_s, wi_s, wv_s, fd_s} !== 8'h00) begin
            bad++; $display("FAIL reset_s: got %0h expected 0", {fl_s, wi_s, wv_s, fd_s});
        end
        rst = 1'b0;
        @(negedge PCLK);
    endtask

    task automatic test_single_winner();
        int cyc; logic got;
        do_reset(); mode = 1'b0;
        start_frame();
        clear_bud(); bud[1] = 3000;
        repeat (19) send_line(640, 5'b00010);
        end_frame(0, cyc, got);
        total++;
        if (got !== 1'b1) begin bad++; $display("FAIL t1_frame_done: got %0b expected 1 (timeout)", got); end
        total++;
        if (wi_a !== 2'd1) begin bad++; $display("FAIL t1_winner_idx: got %0d expected 1", wi_a); end
        total++;
        if (wv_a !== 1'b1) begin bad++; $display("FAIL t1_winner_valid: got %0b expected 1", wv_a); end
        total++;
        if (fl_a !== 4'b0010) begin bad++; $display("FAIL t1_flags: got %b expected 0010", fl_a); end
        total++;
        if (fd_a !== 1'b0) begin bad++; $display("FAIL t1_done_pulse: got %0b expected 0", fd_a); end
    endtask

    task automatic test_tie();
        int cyc; logic got;
        do_reset(); mode = 1'b0;
        start_frame();
        clear_bud(); bud[0] = 2500; bud[2] = 2500;
        repeat (16) send_line(640, 5'b00101);
        end_frame(0, cyc, got);
        total++;
        if (wi_a !== 2'd0 || wv_a !== 1'b1) begin
            bad++; $display("FAIL t2_tie_winner: got idx %0d vld %0b expected idx 0 vld 1", wi_a, wv_a);
        end
        total++;
        if (fl_a !== 4'b0001) begin bad++; $display("FAIL t2_flags_mode0: got %b expected 0001", fl_a); end
        mode = 1'b1;
        clear_bud(); bud[0] = 2500; bud[2] = 2500;
        repeat (16) send_line(640, 5'b00101);
        end_frame(0, cyc, got);
        total++;
        if (fl_a !== 4'b0101) begin bad++; $display("FAIL t2_flags_mode1: got %b expected 0101", fl_a); end
        total++;
        if (wi_a !== 2'd0) begin bad++; $display("FAIL t2_idx_mode1: got %0d expected 0", wi_a); end
        mode = 1'b0;
    endtask

    task automatic test_hysteresis();
        int cyc; logic got;
        int seq [6] = '{3, 3, 1, 3, 3, 3};
        logic [3:0] expf [6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000};
        logic [4:0] m;
        do_reset(); mode = 1'b0;
        start_frame();
        for (int f = 0; f < 6; f++) begin
            clear_bud(); bud[seq[f]] = 1000;
            m = 5'b00001 << seq[f];
            send_line(640, m);
            end_frame(1, cyc, got);
            total++;
            if (fl_h !== expf[f]) begin
                bad++; $display("FAIL t3_flags_f%0d: got %b expected %b", f + 1, fl_h, expf[f]);
            end
            total++;
            if (wi_h !== 2'(seq[f]) || wv_h !== 1'b1) begin
                bad++; $display("FAIL t3_winner_f%0d: got idx %0d vld %0b expected idx %0d vld 1", f + 1, wi_h, wv_h, seq[f]);
            end
        end
    endtask

    task automatic test_excess_pixels();
        int cyc; logic got;
        do_reset(); mode = 1'b0;
        start_frame();
        clear_bud(); bud[4] = 1000;
        repeat (4) send_line(700, 5'b10000);
        end_frame(0, cyc, got);
        total++;
        if ({fl_a, wi_a, wv_a} !== 7'h00) begin
            bad++; $display("FAIL t5_default: got %0h expected 0", {fl_a, wi_a, wv_a});
        end
        total++;
        if ({fl_s, wi_s, wv_s} !== 7'h00) begin
            bad++; $display("FAIL t5_lowthr: got %0h expected 0", {fl_s, wi_s, wv_s});
        end
    endtask

    task automatic test_saturation();
        int cyc; logic got;
        do_reset(); mode = 1'b1;
        start_frame();
        clear_bud(); for (int r = 0; r < 4; r++) bud[r] = 1000;
        repeat (2) send_line(640, 5'b01111);
        end_frame(2, cyc, got);
        total++;
        if (fl_s !== 4'b1111) begin bad++; $display("FAIL t4_sat_flags: got %b expected 1111", fl_s); end
        total++;
        if (wv_s !== 1'b1 || wi_s !== 2'd0) begin
            bad++; $display("FAIL t4_sat_winner: got idx %0d vld %0b expected idx 0 vld 1", wi_s, wv_s);
        end
    endtask

    task automatic test_reset_mid_frame();
        int cyc; int seen; logic got;
        @(negedge PCLK);
        HREF = 1'b1;
        @(negedge PCLK);
        e_pix = 1'b1; hit = 1'b1;
        repeat (10) @(negedge PCLK);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({fl_s, wi_s, wv_s, fd_s} !== 8'h00) begin
            bad++; $display("FAIL t6_async_clear: got %0h expected 0", {fl_s, wi_s, wv_s, fd_s});
        end
        @(negedge PCLK);
        e_pix = 1'b0; hit = 1'b0; HREF = 1'b0;
        @(negedge PCLK);
        rst = 1'b0;
        repeat (2) @(negedge PCLK);
        VSYNC = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge PCLK); #1;
            if (fd_s) seen++;
        end
        @(negedge PCLK);
        VSYNC = 1'b0;
        total++;
        if (seen !== 0) begin bad++; $display("FAIL t6_no_done_first_rise: got %0d pulses expected 0", seen); end
        repeat (3) @(negedge PCLK);
        end_frame(2, cyc, got);
        total++;
        if (got !== 1'b1 || cyc !== 6) begin
            bad++; $display("FAIL t6_latency: got done %0b after %0d cycles expected 1 after 6", got, cyc);
        end
        total++;
        if ({fl_s, wv_s} !== 5'h00) begin bad++; $display("FAIL t6_empty_frame: got %0h expected 0", {fl_s, wv_s}); end
        mode = 1'b0;
    endtask

    initial begin
        clear_bud();
        test_reset();
        test_single_winner();
        test_tie();
        test_hysteresis();
        test_excess_pixels();
        test_saturation();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
